translayer_merge: RTL

Receive-side counterpart of the transaction layer splitter: takes the two 6-bit lane streams (lane 0, lane 1) arriving from the far end and merges them into a single main output FIFO. The main FIFO is drained by the consumer via `pop_main`. Configurable almost-full thresholds (`UMF` for main, `UD` for lanes) produce back-pressure, and an init/idle/active/error state machine mirrors the splitter's status outputs. It sits between the lane receivers and the upper-layer consumer.

---
 rtl/translayer_merge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/translayer_merge.sv
// rtl/translayer_merge.sv - merges two receive lane FIFOs into one main FIFO with threshold back-pressure
// Optional: define TRANSLAYER_MERGE_RR_EN for round-robin lane arbitration (default: lane 0 fixed priority).
module translayer_merge #(
  parameter int DATA_W     = 6,
  parameter int LANE_DEPTH = 4,
  parameter int MAIN_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [7:0]        UMF,
  input  logic [7:0]        UD,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              push_0,
  input  logic              push_1,
  input  logic              pop_main,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              almost_full_0,
  output logic              almost_full_1,
  output logic              main_almost_full,
  output logic              idle_out,
  output logic              active_out,
  output logic              error_out
);
  localparam int LP  = $clog2(LANE_DEPTH);
  localparam int MP  = $clog2(MAIN_DEPTH);
  localparam int LCW = LP + 1;
  localparam int MCW = MP + 1;

  typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
  state_t state_q, state_n;

  logic [DATA_W-1:0] lane_mem [2][LANE_DEPTH];
  logic [DATA_W-1:0] main_mem [MAIN_DEPTH];
  logic [LP-1:0]     lane_wp [2];
  logic [LP-1:0]     lane_rp [2];
  logic [LCW-1:0]    lane_cnt [2];
  logic [LCW-1:0]    lane_cnt_n [2];
  logic [MP-1:0]     main_wp, main_rp;
  logic [MCW-1:0]    main_cnt, main_cnt_n;
  logic [7:0]        ud_q, umf_q, ud_clamp, umf_clamp;
  logic [DATA_W-1:0] din [2];
  logic [1:0]        push, full, push_ok, elig, grant;
  logic              run, ovf, xfer, xfer_lane, pop_ok, any_n;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign push   = {push_1, push_0};
  assign run    = (state_q == S_IDLE) || (state_q == S_ACTIVE);

  // Out-of-range thresholds fall back to the full depth
  assign ud_clamp  = (UD == 8'd0 || UD > 8'(LANE_DEPTH)) ? 8'(LANE_DEPTH) : UD;
  assign umf_clamp = (UMF == 8'd0 || UMF > 8'(MAIN_DEPTH)) ? 8'(MAIN_DEPTH) : UMF;

  assign almost_full_0    = 8'(lane_cnt[0]) >= ud_q;
  assign almost_full_1    = 8'(lane_cnt[1]) >= ud_q;
  assign main_almost_full = 8'(main_cnt) >= umf_q;
  assign idle_out         = (state_q == S_IDLE);
  assign active_out       = (state_q == S_ACTIVE);
  assign error_out        = (state_q == S_ERROR);

  // A full lane flags overflow even if it is being drained this cycle
  always_comb begin
    full    = '0;
    push_ok = '0;
    elig    = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]    = (lane_cnt[i] == LCW'(LANE_DEPTH));
      push_ok[i] = run && push[i] && !full[i];
      elig[i]    = run && (lane_cnt[i] != '0) && !main_almost_full;
    end
  end
  assign ovf = run && |(push & full);

`ifdef TRANSLAYER_MERGE_RR_EN
  logic last_q;

  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  // Remember which lane was served; reset value makes lane 0 win first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else if (xfer) last_q <= xfer_lane;
  end
`else
  always_comb begin
    grant    = '0;
    grant[0] = elig[0];
    grant[1] = elig[1] & ~elig[0];
  end
`endif

  assign xfer      = |grant;
  assign xfer_lane = grant[1];
  assign pop_ok    = pop_main && (state_q != S_RESET) && (main_cnt != '0);

  always_comb begin
    for (int i = 0; i < 2; i++)
      lane_cnt_n[i] = lane_cnt[i] + LCW'(push_ok[i]) - LCW'(grant[i]);
    main_cnt_n = main_cnt + MCW'(xfer) - MCW'(pop_ok);
    any_n = (lane_cnt_n[0] != '0) || (lane_cnt_n[1] != '0) || (main_cnt_n != '0);
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_RESET: state_n = S_INIT;
      S_INIT:  if (!init) state_n = S_IDLE;
      S_IDLE, S_ACTIVE: begin
        if (ovf)        state_n = S_ERROR;
        else if (init)  state_n = S_INIT;
        else if (any_n) state_n = S_ACTIVE;
        else            state_n = S_IDLE;
      end
      S_ERROR: if (init) state_n = S_INIT;
      default: state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET;
      main_wp   <= '0;
      main_rp   <= '0;
      main_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ud_q      <= 8'(LANE_DEPTH);
      umf_q     <= 8'(MAIN_DEPTH);
      for (int i = 0; i < 2; i++) begin
        lane_wp[i]  <= '0;
        lane_rp[i]  <= '0;
        lane_cnt[i] <= '0;
      end
    end else begin
      state_q <= state_n;
      for (int i = 0; i < 2; i++) begin
        if (push_ok[i]) lane_wp[i] <= lane_wp[i] + LP'(1);
        if (grant[i])   lane_rp[i] <= lane_rp[i] + LP'(1);
        lane_cnt[i] <= lane_cnt_n[i];
      end
      if (xfer)   main_wp <= main_wp + MP'(1);
      if (pop_ok) begin
        main_rp  <= main_rp + MP'(1);
        data_out <= main_mem[main_rp];
      end
      main_cnt  <= main_cnt_n;
      valid_out <= pop_ok;
      if (state_q == S_INIT) begin
        ud_q  <= ud_clamp;
        umf_q <= umf_clamp;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push_ok[i]) lane_mem[i][lane_wp[i]] <= din[i];
    if (xfer) main_mem[main_wp] <= lane_mem[xfer_lane][lane_rp[xfer_lane]];
  end
endmodule
